execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
- EX stage of the 5-stage RISC-V pipeline.
- Selects forwarded operands, runs the single-cycle ALU, and resolves branches and jumps.
- Runs iterative RV32M multiply/divide through a stall-generating FSM.
- Drives the EX/MEM pipeline register that feeds the memory stage.

Parameters:
- XLEN, 32, datapath width.
- MD_ITER, 32, iterations per multiply/divide operation.

Ports:
- clk  in  1  clock; all registers update on its rising edge.
- rst  in  1  synchronous, active-low reset.
- RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE, MulDivE  in  1 each  ID/EX controls.
- ResultSrcE  in  2  result select, passed through to MEM.
- ALUControlE  in  4  ALU op code (encoding in Behaviour).
- funct3E  in  3  branch condition, or M-extension op when MulDivE=1.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E, InstrE  in  XLEN each  ID/EX data.
- RdE  in  5  destination register.
- ForwardAE, ForwardBE  in  2 each  forwarding select: 00 = RDxE, 01 = ResultW, 10 = ALUResultM.
- ResultW  in  XLEN  writeback result, forwarding source.
- RegWriteM, MemWriteM  out  1 each  EX/MEM controls.
- ResultSrcM  out  2  EX/MEM result select.
- ALUResultM, WriteDataM, PCPlus4M, InstrM  out  XLEN each  EX/MEM data.
- RdM  out  5  EX/MEM destination register.
- PCSrcE  out  1  redirect fetch (combinational).
- PCTargetE  out  XLEN  redirect target (combinational).
- StallE  out  1  multiply/divide busy; hazard unit holds PC, IF/ID and ID/EX while high.

Behaviour:
- Reset (rst=0 at a clock edge):
  - All EX/MEM outputs go to 0.
  - FSM goes to IDLE, iteration counter clears.
  - StallE=0.
  - PCSrcE follows its combinational equation from the current inputs.
- Operand selection:
  - SrcA = mux(ForwardAE).
  - FwdB = mux(ForwardBE).
  - SrcB = ALUSrcE ? ImmExtE : FwdB.
  - WriteDataM is loaded from FwdB.
- ALU (combinational):
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 slt (signed), 0110 sltu.
  - 0111 sll, 1000 srl, 1001 sra; shift amount is SrcB[4:0].
  - 1010 pass SrcB (lui).
  - Any other code gives 0.
- Branch resolution:
  - funct3 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; compare SrcA against FwdB.
  - Undefined funct3 means not taken.
  - PCSrcE = JumpE | (BranchE & taken).
  - PCTargetE = JalrE ? ((SrcA+ImmExtE) & ~1) : (PCE+ImmExtE).
- EX/MEM register (MulDivE=0): loads every cycle.
  - ALUResultM gets the ALU result.
  - Controls, RdE, PCPlus4E and InstrE pass through.
- Multiply/divide FSM, states IDLE, BUSY, DONE:
  - IDLE with MulDivE=1:
    - StallE=1.
    - Latch SrcA and FwdB; later changes in the forwarding sources do not affect the result.
    - Record signs per funct3.
    - Go to BUSY with count=0.
  - BUSY:
    - StallE=1.
    - One shift-add (mul) or restoring shift-subtract (div) step per cycle on magnitudes.
    - count increments; after count=MD_ITER-1, go to DONE.
  - DONE:
    - StallE=0.
    - Apply sign correction and select the result per funct3: 000 mul (low), 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
    - Load the result into ALUResultM together with the instruction's controls.
    - Return to IDLE.
  - Timing: StallE is high for exactly MD_ITER+1 cycles; the result is visible in ALUResultM on the cycle after DONE.
- While StallE=1:
  - EX/MEM loads a bubble: RegWriteM=0, MemWriteM=0, RdM=0, other fields 0.
  - PCSrcE is forced to 0.
- Division corner cases:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient = 0x80000000; remainder = 0.
- Back-to-back M ops: the second op arrives in the cycle after DONE and starts a fresh IDLE→BUSY sequence; there is no idle gap beyond that.
- Reset mid-operation: the FSM aborts to IDLE, StallE=0, no result is written, and EX/MEM is cleared.

Test Plan:
- Reset release, then add with RD1E=5, RD2E=7, ALUSrcE=0 → next cycle ALUResultM=12 and RdM equals RdE.
- Forwarding: ForwardAE=10 with ALUResultM=0x10, ForwardBE=01 with ResultW=3, ALUControlE=sub → ALUResultM=0xD.
- beq with SrcA=FwdB=9, PCE=0x100, ImmExtE=0x20 → PCSrcE=1, PCTargetE=0x120. jalr with SrcA=0x203, ImmExtE=0 → PCTargetE=0x202.
- mul 0xFFFFFFFF × 2, funct3 000 → StallE high for 33 cycles with bubbles in EX/MEM, then ALUResultM=0xFFFFFFFE. mulh on the same operands → 0xFFFFFFFF.
- div −7/2 → quotient 0xFFFFFFFD; rem −7,2 → 0xFFFFFFFF. divu x/0 → 0xFFFFFFFF. div 0x80000000/−1 → 0x80000000.
- Assert rst=0 at BUSY count=10 → StallE=0 and all EX/MEM outputs 0 on the next cycle. The next M op after reset completes normally in 33 stall cycles.

Source files
------------

// File: rtl/execute_cycle.sv
// execute_cycle: EX stage of a 5-stage RV32IM pipeline.
//   - Selects forwarded operands (RDxE / ResultW / ALUResultM) and runs the ALU.
//   - Resolves branches and jumps combinationally (PCSrcE, PCTargetE).
//   - Runs RV32M multiply/divide iteratively. StallE is held high while the
//     unit is busy.
//   - Drives the EX/MEM pipeline register (RegWriteM .. InstrM).
// Ports: clk, rst (sync, active low), ID/EX controls and data (*E),
//        forwarding selects and ResultW, EX/MEM outputs (*M),
//        PCSrcE/PCTargetE redirect, and StallE.
//
// state | meaning
// IDLE  | no M op in flight; an arriving M op latches its operands here
// BUSY  | one shift-add / shift-subtract step per cycle, MD_ITER steps
// DONE  | sign-correct the result and load it into EX/MEM
module execute_cycle #(
  parameter int XLEN    = 32,
  parameter int MD_ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            JalrE,
  input  logic            ALUSrcE,
  input  logic            MulDivE,
  input  logic [1:0]      ResultSrcE,
  input  logic [3:0]      ALUControlE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] InstrE,
  input  logic [4:0]      RdE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] InstrM,
  output logic [4:0]      RdM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            StallE
);

  localparam int CW = $clog2(MD_ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_e;

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d, b_zero_q, b_zero_d;

  logic              reg_write_q, mem_write_q;
  logic [1:0]        result_src_q;
  logic [XLEN-1:0]   alu_result_q, write_data_q, pc_plus4_q, instr_q;
  logic [4:0]        rd_q;

  logic [XLEN-1:0]   src_a, fwd_b, src_b, alu_res, jalr_sum, md_result;
  logic [XLEN-1:0]   mag_a, mag_b, quot, rem;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              taken, stall, a_signed, b_signed, neg_a, neg_b;

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;
  assign InstrM     = instr_q;
  assign RdM        = rd_q;

  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = alu_result_q;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = alu_result_q;
      default: fwd_b = RD2E;
    endcase
    src_b = ALUSrcE ? ImmExtE : fwd_b;
  end

  always_comb begin
    alu_res = '0;
    case (ALUControlE)
      4'b0000: alu_res = src_a + src_b;
      4'b0001: alu_res = src_a - src_b;
      4'b0010: alu_res = src_a & src_b;
      4'b0011: alu_res = src_a | src_b;
      4'b0100: alu_res = src_a ^ src_b;
      4'b0101: alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'b0110: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      4'b0111: alu_res = src_a << src_b[4:0];
      4'b1000: alu_res = src_a >> src_b[4:0];
      4'b1001: alu_res = $signed(src_a) >>> src_b[4:0];
      4'b1010: alu_res = src_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3E)
      3'b000:  taken = (src_a == fwd_b);
      3'b001:  taken = (src_a != fwd_b);
      3'b100:  taken = ($signed(src_a) < $signed(fwd_b));
      3'b101:  taken = ($signed(src_a) >= $signed(fwd_b));
      3'b110:  taken = (src_a < fwd_b);
      3'b111:  taken = (src_a >= fwd_b);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum  = src_a + ImmExtE;
  assign PCTargetE = JalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + ImmExtE);
  assign PCSrcE    = ~StallE & (JumpE | (BranchE & taken));

  // Operand signedness per M op: mul/mulh/div/rem signed, mulhsu signs only A.
  assign a_signed = (funct3E == 3'b000) || (funct3E == 3'b001) || (funct3E == 3'b010) ||
                    (funct3E == 3'b100) || (funct3E == 3'b110);
  assign b_signed = (funct3E == 3'b000) || (funct3E == 3'b001) ||
                    (funct3E == 3'b100) || (funct3E == 3'b110);
  assign neg_a    = a_signed & src_a[XLEN-1];
  assign neg_b    = b_signed & fwd_b[XLEN-1];
  assign mag_a    = neg_a ? (~src_a + 1'b1) : src_a;
  assign mag_b    = neg_b ? (~fwd_b + 1'b1) : fwd_b;

  // hi holds the partial product (mul) or running remainder (div); lo holds
  // the multiplier being consumed (mul) or the dividend/quotient (div).
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, m_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    f3_d     = f3_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    b_zero_d = b_zero_q;
    stall    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MulDivE) begin
          stall    = 1'b1;
          state_d  = S_BUSY;
          cnt_d    = '0;
          hi_d     = '0;
          lo_d     = funct3E[2] ? mag_a : mag_b;
          m_d      = funct3E[2] ? mag_b : mag_a;
          f3_d     = funct3E;
          neg_a_d  = neg_a;
          neg_b_d  = neg_b;
          b_zero_d = (fwd_b == '0);
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (f3_q[2]) begin
          if (!div_diff[XLEN]) begin
            hi_d = div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == CW'(MD_ITER - 1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign StallE = stall & rst;

  // Divide-by-zero leaves quotient magnitude all ones; sign correction must
  // not touch it. Remainder sign follows the dividend, which also covers x/0.
  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
    quot = b_zero_q ? '1 : ((neg_a_q ^ neg_b_q) ? (~lo_q + 1'b1) : lo_q);
    rem  = neg_a_q ? (~hi_q + 1'b1) : hi_q;
    case (f3_q)
      3'b000:         md_result = prod[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         md_result = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101: md_result = quot;
      default:        md_result = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      m_q          <= '0;
      f3_q         <= '0;
      neg_a_q      <= 1'b0;
      neg_b_q      <= 1'b0;
      b_zero_q     <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      instr_q      <= '0;
      rd_q         <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      f3_q     <= f3_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      b_zero_q <= b_zero_d;
      if (StallE) begin
        reg_write_q  <= 1'b0;
        mem_write_q  <= 1'b0;
        result_src_q <= '0;
        alu_result_q <= '0;
        write_data_q <= '0;
        pc_plus4_q   <= '0;
        instr_q      <= '0;
        rd_q         <= '0;
      end else begin
        reg_write_q  <= RegWriteE;
        mem_write_q  <= MemWriteE;
        result_src_q <= ResultSrcE;
        alu_result_q <= (state_q == S_DONE) ? md_result : alu_res;
        write_data_q <= fwd_b;
        pc_plus4_q   <= PCPlus4E;
        instr_q      <= InstrE;
        rd_q         <= RdE;
      end
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
module tb_execute_cycle;
  localparam int XLEN    = 32;
  localparam int MD_ITER = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE, MulDivE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [3:0]  ALUControlE;
  logic [2:0]  funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, InstrE, ResultW;
  logic [4:0]  RdE;
  logic        RegWriteM, MemWriteM, PCSrcE, StallE;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, InstrM, PCTargetE;
  logic [4:0]  RdM;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_alum;

  execute_cycle #(.XLEN(XLEN), .MD_ITER(MD_ITER)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .JalrE(JalrE), .ALUSrcE(ALUSrcE), .MulDivE(MulDivE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .funct3E(funct3E), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .InstrE(InstrE), .RdE(RdE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .InstrM(InstrM), .RdM(RdM), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults;
    rst = 1'b1;
    {RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE, MulDivE} = '0;
    ResultSrcE = '0; ForwardAE = '0; ForwardBE = '0; ALUControlE = '0; funct3E = '0;
    RD1E = '0; RD2E = '0; ImmExtE = '0; PCE = '0; PCPlus4E = '0; InstrE = '0;
    ResultW = '0; RdE = '0;
  endtask

  // Reference ALU computed from the op table with plain arithmetic.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ext;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + (~b) + 32'd1;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a * (32'd1 << b[4:0]);
      4'd8:  return a / (32'd1 << b[4:0]);
      4'd9: begin
        ext = {{32{a[31]}}, a};
        ext = ext >> b[4:0];
        return ext[31:0];
      end
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b);
    logic lt;
    lt = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] md_ref(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa, sb, sq;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        sq = sa / sb;
        return sq;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        sq = sa % sb;
        return sq;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    RegWriteE = 1'b1; MemWriteE = 1'b1; JumpE = 1'b1; ResultSrcE = 2'b11;
    RD1E = $urandom; RD2E = $urandom; RdE = 5'd17; InstrE = $urandom; PCPlus4E = $urandom;
    tick();
    tick();
    total++;
    if ({RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, InstrM, RdM} !== '0) begin
      bad++;
      $display("FAIL reset_exmem: got %h/%h/%h/%h want all zero", ALUResultM, WriteDataM, InstrM, RdM);
    end
    total++;
    if (StallE !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", StallE); end
    total++;
    if (PCSrcE !== 1'b1) begin bad++; $display("FAIL reset_pcsrc: got %b want 1", PCSrcE); end
    set_defaults();
    exp_alum = '0;
  endtask

  task automatic test_add;
    RD1E = 32'd5; RD2E = 32'd7; ALUControlE = 4'd0; RdE = 5'd9; RegWriteE = 1'b1;
    tick();
    total++;
    if (ALUResultM !== 32'd12) begin bad++; $display("FAIL add_result: got %h want %h", ALUResultM, 32'd12); end
    total++;
    if (RdM !== 5'd9 || RegWriteM !== 1'b1) begin
      bad++; $display("FAIL add_rd: got rd=%0d rw=%b want rd=9 rw=1", RdM, RegWriteM);
    end
    exp_alum = 32'd12;
  endtask

  task automatic test_forward;
    RD1E = 32'h10; RD2E = 32'h0; ALUControlE = 4'd0;
    tick();
    ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'd3; ALUControlE = 4'd1;
    RD1E = $urandom; RD2E = $urandom;
    tick();
    total++;
    if (ALUResultM !== 32'hD) begin bad++; $display("FAIL fwd_sub: got %h want %h", ALUResultM, 32'hD); end
    total++;
    if (WriteDataM !== 32'd3) begin bad++; $display("FAIL fwd_wdata: got %h want %h", WriteDataM, 32'd3); end
    exp_alum = 32'hD;
    set_defaults();
  endtask

  task automatic test_branch;
    RD1E = 32'd9; RD2E = 32'd9; BranchE = 1'b1; funct3E = 3'd0; PCE = 32'h100; ImmExtE = 32'h20;
    #1;
    total++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h120) begin
      bad++; $display("FAIL beq: got src=%b tgt=%h want src=1 tgt=120", PCSrcE, PCTargetE);
    end
    RD2E = 32'd8;
    #1;
    total++;
    if (PCSrcE !== 1'b0) begin bad++; $display("FAIL beq_not_taken: got %b want 0", PCSrcE); end
    BranchE = 1'b0; JumpE = 1'b1; JalrE = 1'b1; RD1E = 32'h203; ImmExtE = 32'h0;
    #1;
    total++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h202) begin
      bad++; $display("FAIL jalr: got src=%b tgt=%h want src=1 tgt=202", PCSrcE, PCTargetE);
    end
    tick();
    exp_alum = alu_ref(4'd0, 32'h203, 32'h8);
    set_defaults();
  endtask

  task automatic test_alu_random;
    logic [31:0] sa, fb, sb, exp_tgt, exp_res;
    logic        exp_src;
    for (int i = 0; i < 200; i++) begin
      ALUControlE = 4'($urandom_range(0, 15));
      ForwardAE = 2'($urandom_range(0, 2)); ForwardBE = 2'($urandom_range(0, 2));
      RD1E = $urandom; RD2E = $urandom; ResultW = $urandom; ImmExtE = $urandom;
      if (i % 4 == 0) RD2E = RD1E;
      ALUSrcE = 1'($urandom); funct3E = 3'($urandom); BranchE = 1'($urandom);
      JumpE = ($urandom_range(0, 3) == 0); JalrE = 1'($urandom); PCE = $urandom;
      RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ResultSrcE = 2'($urandom);
      RdE = 5'($urandom); PCPlus4E = $urandom; InstrE = $urandom;
      sa = (ForwardAE == 2'd0) ? RD1E : (ForwardAE == 2'd1) ? ResultW : exp_alum;
      fb = (ForwardBE == 2'd0) ? RD2E : (ForwardBE == 2'd1) ? ResultW : exp_alum;
      sb = ALUSrcE ? ImmExtE : fb;
      exp_src = JumpE | (BranchE & br_ref(funct3E, sa, fb));
      exp_tgt = JalrE ? ((sa + ImmExtE) & 32'hFFFF_FFFE) : (PCE + ImmExtE);
      exp_res = alu_ref(ALUControlE, sa, sb);
      #1;
      total++;
      if (PCSrcE !== exp_src || PCTargetE !== exp_tgt) begin
        bad++;
        $display("FAIL rand_branch[%0d]: got src=%b tgt=%h want src=%b tgt=%h", i, PCSrcE, PCTargetE, exp_src, exp_tgt);
      end
      tick();
      total++;
      if (ALUResultM !== exp_res || WriteDataM !== fb) begin
        bad++;
        $display("FAIL rand_alu[%0d] op=%0d: got res=%h wd=%h want res=%h wd=%h", i, ALUControlE, ALUResultM, WriteDataM, exp_res, fb);
      end
      total++;
      if ({RegWriteM, MemWriteM, ResultSrcM, RdM, PCPlus4M, InstrM} !==
          {RegWriteE, MemWriteE, ResultSrcE, RdE, PCPlus4E, InstrE}) begin
        bad++;
        $display("FAIL rand_ctrl[%0d]: got rd=%0d instr=%h want rd=%0d instr=%h", i, RdM, InstrM, RdE, InstrE);
      end
      exp_alum = exp_res;
    end
    set_defaults();
  endtask

  // Directed M ops first, then random ones, issued back to back.
  task automatic test_muldiv;
    logic [2:0]  tf3 [8] = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd5, 3'd4, 3'd6, 3'd7};
    logic [31:0] ta  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'h0000_1234, 32'h8000_0000, 32'h8000_0000, 32'h0000_1234};
    logic [31:0] tb  [8] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] te  [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h0000_1234};
    logic [31:0] a, b, e;
    logic [2:0]  f3;
    logic [4:0]  rd;
    for (int i = 0; i < 24; i++) begin
      if (i < 8) begin
        f3 = tf3[i]; a = ta[i]; b = tb[i]; e = te[i];
        ForwardAE = 2'b00; RD1E = a;
      end else begin
        f3 = 3'($urandom); a = $urandom; b = (i % 5 == 0) ? 32'd0 : $urandom;
        if (i % 3 == 0) b = b >> 20;
        e = md_ref(f3, a, b);
        ForwardAE = 2'b01; ResultW = a; RD1E = $urandom;
      end
      rd = 5'($urandom_range(1, 31));
      MulDivE = 1'b1; funct3E = f3; ForwardBE = 2'b00; RD2E = b;
      ALUSrcE = 1'b1; ImmExtE = $urandom; ALUControlE = 4'($urandom);
      RegWriteE = 1'b1; RdE = rd; JumpE = 1'b1; InstrE = $urandom;
      #1;
      for (int k = 1; k <= MD_ITER + 1; k++) begin
        total++;
        if (StallE !== 1'b1 || PCSrcE !== 1'b0) begin
          bad++; $display("FAIL md_stall[%0d] cyc=%0d: got stall=%b pcsrc=%b want 1/0", i, k, StallE, PCSrcE);
        end
        if (k >= 2) begin
          total++;
          if ({RegWriteM, MemWriteM, RdM, ALUResultM, InstrM} !== '0) begin
            bad++; $display("FAIL md_bubble[%0d] cyc=%0d: got rw=%b rd=%0d res=%h want zeros", i, k, RegWriteM, RdM, ALUResultM);
          end
        end
        tick();
        RD1E = $urandom; RD2E = $urandom; ResultW = $urandom;
      end
      JumpE = 1'b0;
      #1;
      total++;
      if (StallE !== 1'b0) begin bad++; $display("FAIL md_done_stall[%0d]: got %b want 0", i, StallE); end
      tick();
      total++;
      if (ALUResultM !== e || RdM !== rd || RegWriteM !== 1'b1) begin
        bad++;
        $display("FAIL md_result[%0d] f3=%0d a=%h b=%h: got %h rd=%0d want %h rd=%0d", i, f3, a, b, ALUResultM, RdM, e, rd);
      end
      exp_alum = e;
    end
    set_defaults();
  endtask

  task automatic test_reset_mid_op;
    int          cnt;
    logic [31:0] e;
    MulDivE = 1'b1; funct3E = 3'd0; RD1E = 32'd1234; RD2E = 32'd567; RegWriteE = 1'b1; RdE = 5'd4;
    for (int k = 0; k < 11; k++) tick();
    rst = 1'b0;
    tick();
    total++;
    if (StallE !== 1'b0 ||
        {RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, InstrM, RdM} !== '0) begin
      bad++; $display("FAIL mid_reset: got stall=%b res=%h rd=%0d want 0/0/0", StallE, ALUResultM, RdM);
    end
    rst = 1'b1;
    funct3E = 3'd3; RD1E = $urandom; RD2E = $urandom;
    e = md_ref(3'd3, RD1E, RD2E);
    cnt = 0;
    #1;
    while (StallE === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    total++;
    if (cnt != MD_ITER + 1) begin bad++; $display("FAIL post_reset_stall: got %0d want %0d", cnt, MD_ITER + 1); end
    tick();
    total++;
    if (ALUResultM !== e || RdM !== 5'd4) begin
      bad++; $display("FAIL post_reset_result: got %h rd=%0d want %h rd=4", ALUResultM, RdM, e);
    end
    set_defaults();
  endtask

  initial begin
    set_defaults();
    rst = 1'b0;
    exp_alum = '0;
    test_reset();
    test_add();
    test_forward();
    test_branch();
    test_alu_random();
    test_muldiv();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
